div8_seq: RTL and testbench

DIV8_SEQ -- requirements
Module: div8_seq

---
 rtl/div8_seq_pkg.sv | 11 +
 rtl/div8_seq_sub8.sv | 14 +
 rtl/div8_seq.sv | 94 +++++++++
 tb/tb_div8_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div8_seq_pkg.sv
// Shared constants and state encoding for the sequential 8-bit divider.
package div8_seq_pkg;
  localparam int DATA_W = 8;
  localparam int ITERS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div8_seq_sub8.sv
// 8-bit unsigned subtractor with borrow in/out; the divider's only subtractor.
module sub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] diff,
  output logic       bout
);
  logic [8:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
  assign diff = full[7:0];
  assign bout = full[8];
endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider: 8 RUN cycles, one quotient bit per cycle, MSB first.
// Handshake: start is accepted only in IDLE; done pulses for one cycle with valid results.
module div8_seq
  import div8_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   dividend,
  input  logic [DATA_W-1:0]   divisor,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   quotient,
  output logic [DATA_W-1:0]   remainder,
  output logic                div_by_zero
);
  state_t            state_q, state_d;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] r_work, q_work, dvsr;

  logic [DATA_W:0]   p;
  logic [DATA_W-1:0] sub_diff, r_next, q_next;
  logic              sub_bout, take;

  // q_work starts as the dividend; its MSB feeds each step while quotient bits shift in at the LSB.
  assign p = {r_work, q_work[DATA_W-1]};

  sub8 u_sub8 (
    .a    (p[DATA_W-1:0]),
    .b    (dvsr),
    .bin  (1'b0),
    .diff (sub_diff),
    .bout (sub_bout)
  );

  assign take   = p[DATA_W] | ~sub_bout;
  assign r_next = take ? sub_diff : p[DATA_W-1:0];
  assign q_next = {q_work[DATA_W-2:0], take};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (divisor != '0) ? RUN : DONE;
      RUN:  if (cnt_q == 3'(ITERS - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      r_work      <= '0;
      q_work      <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q       <= '0;
            r_work      <= '0;
            q_work      <= dividend;
            dvsr        <= divisor;
            div_by_zero <= 1'b0;
            // Zero divisor skips RUN entirely and publishes the saturated result now.
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt_q  <= cnt_q + 3'd1;
          r_work <= r_next;
          q_work <= q_next;
          if (cnt_q == 3'(ITERS - 1)) begin
            quotient  <= q_next;
            remainder <= r_next;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed table, hand-written corner sequences, random vs. arithmetic model.
module tb_div8_seq;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int tests_run = 0;
  int tests_failed = 0;

  div8_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: plain unsigned arithmetic from the divider's rules.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dbz, output int lat);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dbz = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; dbz = 1'b0; lat = 9;
    end
  endfunction

  // Driver: start a division; optionally poke a stray start at cycle poke_k.
  // Returns done latency in cycles after the accepting edge (-1 on timeout),
  // plus flags for busy dropping early and outputs moving before done.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int poke_k,
                         output int lat, output int busy_ok, output int hold_ok,
                         output int pulse_ok);
    logic [7:0] prev_q, prev_r;
    @(negedge clk);
    prev_q = quotient; prev_r = remainder;
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_ok = 1; hold_ok = 1; pulse_ok = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == poke_k) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_ok = 0;
      if (done) begin
        lat = k;
        break;
      end
      if (quotient !== prev_q || remainder !== prev_r) hold_ok = 0;
      @(negedge clk);
    end
    start = 1'b0;
    if (lat > 0) begin
      @(negedge clk);
      pulse_ok = (!done && !busy) ? 1 : 0;
    end
  endtask

  task automatic apply(input string tag, input logic [7:0] a, input logic [7:0] b, input int poke_k);
    logic [7:0] eq, er;
    logic       edbz;
    int         elat, lat, bok, hok, pok;
    model(a, b, eq, er, edbz, elat);
    run_div(a, b, poke_k, lat, bok, hok, pok);
    check({tag, " latency"}, lat, elat);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, edbz);
    check({tag, " busy_held"}, bok, 1);
    check({tag, " no_intermediate"}, hok, 1);
    check({tag, " done_one_cycle"}, pok, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", div_by_zero, 0);
    rst = 1'b0;

    // Directed table: expected values written from hand arithmetic.
    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9});
    vecs.push_back('{8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 1});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9});
    vecs.push_back('{8'd250, 8'd16,  8'd15,  8'd10,  1'b0, 9});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9});
    vecs.push_back('{8'd128, 8'd128, 8'd1,   8'd0,   1'b0, 9});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9});
    for (int i = 0; i < vecs.size(); i++) begin
      int lat, bok, hok, pok;
      run_div(vecs[i].a, vecs[i].b, 0, lat, bok, hok, pok);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
      check($sformatf("vec%0d dbz", i), div_by_zero, vecs[i].dbz);
      check($sformatf("vec%0d busy_held", i), bok, 1);
      check($sformatf("vec%0d done_one_cycle", i), pok, 1);
      // Results persist in IDLE.
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d hold quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d hold remainder", i), remainder, vecs[i].r);
    end

    // Stray start with 9/3 during RUN is ignored.
    apply("ignore_start", 8'd5, 8'd9, 3);
    repeat (2) @(negedge clk);
    check("ignore_start idle busy", busy, 0);
    check("ignore_start hold q", quotient, 0);
    check("ignore_start hold r", remainder, 5);

    // Reset in the 4th RUN cycle kills the division.
    begin
      int saw_done;
      @(negedge clk);
      dividend = 8'd250; divisor = 8'd16; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset quotient", quotient, 0);
      check("midreset remainder", remainder, 0);
      check("midreset dbz", div_by_zero, 0);
      saw_done = 0;
      for (int k = 0; k < 12; k++) begin
        if (done || busy) saw_done = 1;
        @(negedge clk);
      end
      check("midreset no done", saw_done, 0);
    end
    apply("restart", 8'd250, 8'd16, 0);

    // start together with rst is discarded.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 8'd40; divisor = 8'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start busy", busy, 0);
    @(negedge clk);
    check("rst_start still idle", busy, 0);

    // Random operands, with extra weight on zero divisors.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      apply($sformatf("rand%0d", i), a, b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
